// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined add/subtract, one SEG-bit slice per stage, valid/ready flow control
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;
  logic adv;
  if (WIDTH < 1 || WIDTH % SEG != 0) begin : g_bad
    $error("pipe_addsub: WIDTH must be a positive multiple of SEG");
  end
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;
    logic [WIDTH-1:LO] ai, bi;
    logic [HI-1:0] sn, sr;
    logic [SEG:0] t;
    logic ci, vi, cr, vr;
    if (k == 0) begin : g_in
      assign ai = a;
      assign bi = sub ? ~b : b;
      assign ci = sub ? ~cin : cin;
      assign vi = in_valid;
      assign sn = t[SEG-1:0];
    end else begin : g_mid
      assign ai = g_st[k-1].g_op.ar;
      assign bi = g_st[k-1].g_op.br;
      assign ci = g_st[k-1].cr;
      assign vi = g_st[k-1].vr;
      assign sn = {t[SEG-1:0], g_st[k-1].sr};
    end
    assign t = {1'b0, ai[HI-1:LO]} + {1'b0, bi[HI-1:LO]} + {{SEG{1'b0}}, ci};
    // slice result, carry and valid advance together; everything holds on stall
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sr <= '0;
        cr <= 1'b0;
        vr <= 1'b0;
      end else if (adv) begin
        sr <= sn;
        cr <= t[SEG];
        vr <= vi;
      end
    if (k < STAGES - 1) begin : g_op
      logic [WIDTH-1:HI] ar, br;
      // carry the not-yet-added operand slices (including both MSBs) to the next stage
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          ar <= '0;
          br <= '0;
        end else if (adv) begin
          ar <= ai[WIDTH-1:HI];
          br <= bi[WIDTH-1:HI];
        end
    end else begin : g_ovf
      logic vo;
      // last slice holds the MSBs, so signed overflow is decided here
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) vo <= 1'b0;
        else if (adv) vo <= (ai[WIDTH-1] == bi[WIDTH-1]) && (t[SEG-1] != ai[WIDTH-1]);
    end
  end
  assign sum = g_st[STAGES-1].sr;
  assign cout = g_st[STAGES-1].cr;
  assign out_valid = g_st[STAGES-1].vr;
  assign ovf = g_st[STAGES-1].g_ovf.vo;
endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parameterised, pipelined add/subtract unit; successor to the team's 4-bit combinational adder.
- Splits a WIDTH-bit operation into SEG-bit slices, with one slice per pipeline stage and the carry registered between stages.
- Exposes a valid/ready stream interface so it can sit in datapaths that stall.
- Adds subtract mode and a signed-overflow flag.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 1.
- SEG, 4, slice width per stage; WIDTH % SEG must be 0, else $error at elaboration.
- STAGES, WIDTH/SEG (derived localparam, not overridable): pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  unit accepts operands this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  add: carry out; sub: NOT borrow (1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits, out_valid, sum, cout and ovf go to 0 immediately.
  - in_ready follows its combinational definition.
  - Operation resumes on the first clk edge after rst_n rises.
- Arithmetic:
  - Operand prep at input: bx = sub ? ~b : b; c0 = sub ? ~cin : cin.
  - Result: {cout,sum} = a + bx + c0 (WIDTH+1 bits).
  - ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]).
- Pipeline:
  - Stage k (0..STAGES-1) adds slice [k*SEG +: SEG] of a and bx plus the carry registered from stage k-1 (stage 0 uses c0).
  - Each stage registers: the slice result; the carry; the untouched upper operand slices; the lower result slices already computed; a[MSB] and bx[MSB] for ovf; and a valid bit.
- Flow control:
  - Single global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational; it must not depend on in_valid).
  - Accept happens when in_valid && in_ready. The accepted transaction enters stage 0 on that edge.
  - When adv = 1, every stage shifts one step and bubbles travel as valid = 0.
  - When adv = 0, all stage registers hold, including sum, cout, ovf and out_valid.
  - Bubbles are not squeezed out.
- Latency:
  - An operation accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, when STAGES > 1 and there is no stall.
  - The last stage register drives the outputs directly.
  - For STAGES = 1 the result is valid the cycle after acceptance.
- Throughput: one result per cycle when out_ready stays high.
- Output holding: while out_valid && !out_ready, sum, cout and ovf must stay stable. Results leave in acceptance order; none is dropped or duplicated.
- Boundary cases:
  - in_valid = 0 with adv = 1 inserts a bubble.
  - Operands applied while in_ready = 0 are ignored.
  - Simultaneous out handshake and new accept is legal: the pipe shifts.
  - cin and sub are sampled only at accept.
  - With WIDTH = SEG the unit degenerates to a registered adder.
- Reset mid-operation: all in-flight results are discarded; out_valid = 0 until a new operation has propagated through.

Test Plan (WIDTH=16, SEG=4, STAGES=4):
- Add with carry: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → 4 cycles after accept, sum=0x0000, cout=1, ovf=0, out_valid high for exactly 1 cycle.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0, add → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0. Then a=0x0009, b=0x0003, cin=1, sub=1 → sum=0x0005, cout=1.
- Backpressure: accept 6 back-to-back adds (i + 0x0100*i); hold out_ready=0 for 3 cycles once out_valid rises → in_ready=0 and outputs frozen during the stall. All 6 results arrive in order, none lost or repeated.
- Reset mid-flight: accept 3 ops, pulse rst_n low between clock edges → out_valid=0, sum=0 immediately, none of the 3 results appear. A new op after release returns its correct result 4 cycles after accept.
- Random regression: 2000 random a, b, cin, sub with random in_valid and out_ready → every result equals a scoreboard model of {cout,sum} and ovf. Repeat with WIDTH=8/SEG=8 and WIDTH=32/SEG=8.
